// File: rtl/accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accum_sequencer
// Brief    : Sequences operand pairs through an external adder stage and keeps
//            two running accumulators made purely of the stage's results.
//            One job accumulates num_terms pairs, then emits the result with a
//            one-cycle result_valid pulse.
//            Optional per-term watchdog enabled by defining ACCUM_SEQ_TIMEOUT_EN;
//            without it timeout_err is tied low and WAIT waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module accum_sequencer #(
    parameter int                     FLOAT_DATA_WIDTH = 32,
    parameter int                     COUNT_WIDTH      = 10,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT_CYCLES   = 10'd64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        go,
    input  logic [COUNT_WIDTH-1:0]      num_terms,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FLOAT_DATA_WIDTH-1:0] in_val_1,
    input  logic [FLOAT_DATA_WIDTH-1:0] in_val_2,
    output logic                        stage_start,
    output logic [FLOAT_DATA_WIDTH-1:0] stage_val_1,
    output logic [FLOAT_DATA_WIDTH-1:0] stage_val_2,
    output logic [FLOAT_DATA_WIDTH-1:0] stage_current_1,
    output logic [FLOAT_DATA_WIDTH-1:0] stage_current_2,
    input  logic                        stage_working,
    input  logic                        stage_done,
    input  logic [FLOAT_DATA_WIDTH-1:0] stage_new_1,
    input  logic [FLOAT_DATA_WIDTH-1:0] stage_new_2,
    output logic [FLOAT_DATA_WIDTH-1:0] acc_out_1,
    output logic [FLOAT_DATA_WIDTH-1:0] acc_out_2,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_state_next;

    logic [COUNT_WIDTH-1:0]      r_remaining;
    logic [FLOAT_DATA_WIDTH-1:0] r_acc_1;
    logic [FLOAT_DATA_WIDTH-1:0] r_acc_2;
    logic [FLOAT_DATA_WIDTH-1:0] r_stage_val_1;
    logic [FLOAT_DATA_WIDTH-1:0] r_stage_val_2;
    logic [FLOAT_DATA_WIDTH-1:0] r_acc_out_1;
    logic [FLOAT_DATA_WIDTH-1:0] r_acc_out_2;
    logic                        r_result_valid;

    logic                        w_go_accept;
    logic                        w_fetch;
    logic                        w_capture;
    logic                        w_timeout;
    logic                        w_tmo_hit;
    logic                        w_last_term;
    logic                        w_in_ready;
    logic                        w_stage_start;

    // The term being captured is the last one when one term remains.
    assign w_last_term = (r_remaining == c_ONE);

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        w_state_next  = r_state;
        w_go_accept   = 1'b0;
        w_fetch       = 1'b0;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        w_in_ready    = 1'b0;
        w_stage_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clk_en && go) begin
                    w_go_accept  = 1'b1;
                    w_state_next = (num_terms == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_in_ready = clk_en;
                if (clk_en && in_valid) begin
                    w_fetch      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_stage_start = 1'b1;
                // A done arriving with the working acknowledge counts as a WAIT completion.
                if (stage_working && stage_done) begin
                    w_capture    = 1'b1;
                    w_state_next = w_last_term ? ST_FINISH : ST_FETCH;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (stage_working) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stage_done) begin
                    w_capture    = 1'b1;
                    w_state_next = w_last_term ? ST_FINISH : ST_FETCH;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: accumulators only ever take stage results, no local arithmetic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining    <= '0;
            r_acc_1        <= '0;
            r_acc_2        <= '0;
            r_stage_val_1  <= '0;
            r_stage_val_2  <= '0;
            r_acc_out_1    <= '0;
            r_acc_out_2    <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_go_accept) begin
                r_acc_1     <= '0;
                r_acc_2     <= '0;
                r_remaining <= num_terms;
            end
            if (w_fetch) begin
                r_stage_val_1 <= in_val_1;
                r_stage_val_2 <= in_val_2;
            end
            if (w_capture) begin
                r_acc_1     <= stage_new_1;
                r_acc_2     <= stage_new_2;
                r_remaining <= r_remaining - c_ONE;
            end
            // Result registers hold until the next FINISH.
            if (r_state == ST_FINISH) begin
                r_acc_out_1    <= r_acc_1;
                r_acc_out_2    <= r_acc_2;
                r_result_valid <= 1'b1;
            end
        end
    end

`ifdef ACCUM_SEQ_TIMEOUT_EN
    localparam logic [COUNT_WIDTH-1:0] c_TMO_LAST = TIMEOUT_CYCLES - c_ONE;

    logic [COUNT_WIDTH-1:0] r_tmo_cnt;
    logic                   r_timeout_err;

    // The count reaches its last value on the TIMEOUT_CYCLES-th ISSUE/WAIT cycle.
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    // Per-term watchdog: restarts on ISSUE entry, error is sticky until next go.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
                r_tmo_cnt <= r_tmo_cnt + c_ONE;
            end
            if (w_go_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign timeout_err  = 1'b0;
    assign w_unused_tmo = ^{TIMEOUT_CYCLES, w_timeout};
`endif

    assign in_ready        = w_in_ready;
    assign stage_start     = w_stage_start;
    assign busy            = (r_state != ST_IDLE);
    assign stage_val_1     = r_stage_val_1;
    assign stage_val_2     = r_stage_val_2;
    assign stage_current_1 = r_acc_1;
    assign stage_current_2 = r_acc_2;
    assign acc_out_1       = r_acc_out_1;
    assign acc_out_2       = r_acc_out_2;
    assign result_valid    = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_accum_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_accum_sequencer
// Brief    : Self-checking bench for accum_sequencer with a behavioural adder
//            stage (integer-valued floats) and directed job vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_sequencer;

    localparam int FW = 32;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_en = 1'b0;
    logic          go = 1'b0;
    logic [CW-1:0] num_terms = '0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_val_1 = '0;
    logic [FW-1:0] in_val_2 = '0;
    logic          in_ready;
    logic          stage_start;
    logic [FW-1:0] stage_val_1, stage_val_2;
    logic [FW-1:0] stage_current_1, stage_current_2;
    logic          stage_working, stage_done;
    logic [FW-1:0] stage_new_1, stage_new_2;
    logic [FW-1:0] acc_out_1, acc_out_2;
    logic          result_valid, busy, timeout_err;

    // stage model and manual overrides
    logic          m_en = 1'b0, m_hang = 1'b0;
    int            m_lat = 0;
    int            m_cnt = 0;
    logic          m_active = 1'b0, m_working = 1'b0, m_done = 1'b0;
    logic [FW-1:0] m_new1 = '0, m_new2 = '0;
    logic          man_working = 1'b0, man_done = 1'b0;
    logic [FW-1:0] man_new1 = '0, man_new2 = '0;

    int checks = 0;
    int failures = 0;
    int ss_rises = 0;
    int rv_pulses = 0;
    logic prev_ss = 1'b0, prev_rv = 1'b0;

    assign stage_working = m_working | man_working;
    assign stage_done    = m_done | man_done;
    assign stage_new_1   = man_done ? man_new1 : m_new1;
    assign stage_new_2   = man_done ? man_new2 : m_new2;

    accum_sequencer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .go(go), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready), .in_val_1(in_val_1), .in_val_2(in_val_2),
        .stage_start(stage_start), .stage_val_1(stage_val_1), .stage_val_2(stage_val_2),
        .stage_current_1(stage_current_1), .stage_current_2(stage_current_2),
        .stage_working(stage_working), .stage_done(stage_done),
        .stage_new_1(stage_new_1), .stage_new_2(stage_new_2),
        .acc_out_1(acc_out_1), .acc_out_2(acc_out_2), .result_valid(result_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // integer-valued single precision helpers
    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [23:0] m;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 24; b++) if (n[b]) p = b;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // adder stage model: acknowledges a start, returns sums m_lat negedges later
    always @(negedge clk) begin
        if (!rst || !m_en) begin
            m_active  = 1'b0;
            m_working = 1'b0;
            m_done    = 1'b0;
        end else if (m_done) begin
            m_done    = 1'b0;
            m_working = 1'b0;
            m_active  = 1'b0;
        end else if (!m_active && stage_start) begin
            m_active  = 1'b1;
            m_working = 1'b1;
            m_new1    = i2f(f2i(stage_current_1) + f2i(stage_val_1));
            m_new2    = i2f(f2i(stage_current_2) + f2i(stage_val_2));
            m_cnt     = m_lat;
            if (m_cnt == 0 && !m_hang) m_done = 1'b1;
        end else if (m_active && !m_hang) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_done = 1'b1;
        end
    end

    // event counters
    always @(negedge clk) begin
        if (stage_start && !prev_ss) ss_rises = ss_rises + 1;
        if (result_valid && !prev_rv) rv_pulses = rv_pulses + 1;
        prev_ss = stage_start;
        prev_rv = result_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_result(input string nm);
        int c;
        c = 0;
        while (!result_valid && c < 400) begin
            tick();
            c++;
        end
        chk({nm, "_rv_seen"}, 64'(result_valid), 64'd1);
    endtask

    typedef struct {
        logic [CW-1:0] n;
        logic [31:0]   v1;
        logic [31:0]   v2;
        int            lat;
        logic [31:0]   e1;
        logic [31:0]   e2;
        int            starts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int ss0, rv0;
        vecs[0] = '{10'd1, 32'h3F800000, 32'h40000000, 2, 32'h3F800000, 32'h40000000, 1};
        vecs[1] = '{10'd3, 32'h3F800000, 32'h3F800000, 5, 32'h40400000, 32'h40400000, 3};
        vecs[2] = '{10'd2, 32'h40000000, 32'h40400000, 0, 32'h40800000, 32'h40C00000, 2};
        vecs[3] = '{10'd4, 32'h3F800000, 32'h40000000, 1, 32'h40800000, 32'h41000000, 4};
        vecs[4] = '{10'd0, 32'h40400000, 32'h40400000, 1, 32'h00000000, 32'h00000000, 0};

        // reset state
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_stage_start", 64'(stage_start), 0);
        chk("rst_result_valid", 64'(result_valid), 0);
        chk("rst_timeout_err", 64'(timeout_err), 0);
        chk("rst_acc_out", {acc_out_1, acc_out_2}, 0);
        chk("rst_stage_val", {stage_val_1, stage_val_2}, 0);
        chk("rst_current", {stage_current_1, stage_current_2}, 0);
        rst = 1'b1;
        tick();

        // table-driven jobs
        for (int i = 0; i < 5; i++) begin
            ss0 = ss_rises;
            rv0 = rv_pulses;
            m_en = 1'b1; m_lat = vecs[i].lat;
            clk_en = 1'b1; in_valid = 1'b1;
            in_val_1 = vecs[i].v1; in_val_2 = vecs[i].v2;
            num_terms = vecs[i].n; go = 1'b1;
            tick();
            go = 1'b0;
            wait_result($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_acc1", i), 64'(acc_out_1), 64'(vecs[i].e1));
            chk($sformatf("vec%0d_acc2", i), 64'(acc_out_2), 64'(vecs[i].e2));
            tick();
            chk($sformatf("vec%0d_rv_1cycle", i), 64'(result_valid), 0);
            chk($sformatf("vec%0d_hold", i), {acc_out_1, acc_out_2}, {vecs[i].e1, vecs[i].e2});
            tick();
            chk($sformatf("vec%0d_starts", i), 64'(ss_rises - ss0), 64'(vecs[i].starts));
            chk($sformatf("vec%0d_pulses", i), 64'(rv_pulses - rv0), 1);
        end

        // zero terms: result_valid two cycles after go, no start
        ss0 = ss_rises;
        num_terms = '0; go = 1'b1;
        tick();
        go = 1'b0;
        chk("zero_rv_c1", 64'(result_valid), 0);
        chk("zero_busy_c1", 64'(busy), 1);
        tick();
        chk("zero_rv_c2", 64'(result_valid), 1);
        chk("zero_acc", {acc_out_1, acc_out_2}, 0);
        tick();
        chk("zero_no_start", 64'(ss_rises - ss0), 0);

        // ignored go, clk_en gating and stray done in FETCH
        m_en = 1'b0; in_valid = 1'b0;
        num_terms = 10'd1; go = 1'b1;
        tick();
        chk("gate_fetch_ready", 64'(in_ready), 1);
        clk_en = 1'b0; in_valid = 1'b1;
        in_val_1 = 32'h40000000; in_val_2 = 32'h40400000;
        num_terms = 10'd5;
        man_done = 1'b1; man_new1 = 32'h41200000; man_new2 = 32'h41200000;
        repeat (3) tick();
        chk("gate_in_ready", 64'(in_ready), 0);
        chk("gate_no_start", 64'(stage_start), 0);
        chk("gate_busy", 64'(busy), 1);
        chk("gate_no_fetch", {stage_val_1, stage_val_2}, {32'h3F800000, 32'h40000000});
        chk("gate_stray_done", {stage_current_1, stage_current_2}, 0);
        ss0 = ss_rises;
        go = 1'b0; man_done = 1'b0; clk_en = 1'b1;
        m_en = 1'b1; m_lat = 2;
        wait_result("gate");
        chk("gate_acc", {acc_out_1, acc_out_2}, {32'h40000000, 32'h40400000});
        tick();
        chk("gate_starts", 64'(ss_rises - ss0), 1);

        // stage_start held until working; one-cycle done-to-ready latency
        m_en = 1'b0;
        in_val_1 = 32'h3F800000; in_val_2 = 32'h40000000;
        num_terms = 10'd2; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        chk("hs_start", 64'(stage_start), 1);
        chk("hs_val", {stage_val_1, stage_val_2}, {32'h3F800000, 32'h40000000});
        tick();
        chk("hs_start_held", 64'(stage_start), 1);
        man_working = 1'b1;
        tick();
        chk("hs_start_drop", 64'(stage_start), 0);
        man_working = 1'b0;
        man_done = 1'b1; man_new1 = 32'h3F800000; man_new2 = 32'h3F800000;
        tick();
        man_done = 1'b0;
        chk("hs_ready_lat", 64'(in_ready), 1);
        chk("hs_capture", {stage_current_1, stage_current_2}, {32'h3F800000, 32'h3F800000});
        m_en = 1'b1; m_lat = 3;
        wait_result("hs");
        chk("hs_acc", {acc_out_1, acc_out_2}, {32'h40000000, 32'h40400000});
        tick();

        // reset in WAIT, then late done must be ignored
        rv0 = rv_pulses;
        m_hang = 1'b1;
        in_val_1 = 32'h3F800000; in_val_2 = 32'h3F800000;
        num_terms = 10'd2; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        chk("rw_busy", 64'(busy), 1);
        chk("rw_start_low", 64'(stage_start), 0);
        chk("rw_tmo_low", 64'(timeout_err), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        man_done = 1'b1; man_new1 = 32'h40A00000; man_new2 = 32'h40A00000;
        tick();
        man_done = 1'b0;
        repeat (2) tick();
        chk("rw_idle", 64'(busy), 0);
        chk("rw_outs", {acc_out_1, acc_out_2, stage_current_1, stage_current_2}, 0);
        chk("rw_stage_val", {stage_val_1, stage_val_2}, 0);
        chk("rw_no_rv", 64'(rv_pulses - rv0), 0);
        m_hang = 1'b0;

`ifdef ACCUM_SEQ_TIMEOUT_EN
        // watchdog: stage never completes
        rv0 = rv_pulses;
        m_hang = 1'b1;
        num_terms = 10'd1; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (60) tick();
        chk("tmo_still_busy", 64'(busy), 1);
        chk("tmo_not_yet", 64'(timeout_err), 0);
        repeat (10) tick();
        chk("tmo_idle", 64'(busy), 0);
        chk("tmo_err", 64'(timeout_err), 1);
        chk("tmo_no_rv", 64'(rv_pulses - rv0), 0);
        m_hang = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("tmo_cleared", 64'(timeout_err), 0);
        wait_result("tmo");
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
